// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single AXI4-Lite style master port.
// One transaction in flight; alternating priority when both requesters collide.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,

  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  input  logic [3:0]  r0_wstrb,
  output logic        r0_ack,
  output logic [31:0] r0_rdata,
  output logic        r0_err,

  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  input  logic [3:0]  r1_wstrb,
  output logic        r1_ack,
  output logic [31:0] r1_rdata,
  output logic        r1_err,

  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready
);

  typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, RESP} state_t;

  state_t      state_reg;
  logic        grant_reg;
  logic        last_grant_reg;
  logic [31:0] araddr_reg;
  logic [31:0] awaddr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  wstrb_reg;
  logic        arvalid_reg;
  logic        rready_reg;
  logic        awvalid_reg;
  logic        wvalid_reg;
  logic        bready_reg;
  logic        r0_ack_reg;
  logic        r1_ack_reg;
  logic [31:0] r0_rdata_reg;
  logic [31:0] r1_rdata_reg;
  logic        r0_err_reg;
  logic        r1_err_reg;

  logic        sel;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;
  logic        aw_done;
  logic        w_done;
  logic        unused_resp_lsb;

  // Only resp[1] distinguishes an error; the low bit carries no meaning here.
  assign unused_resp_lsb = m_axi_rresp[0] ^ m_axi_bresp[0];

  // On a collision, the requester that did not win last time goes first.
  always_comb begin
    sel = 1'b0;
    if (r0_req && r1_req)
      sel = ~last_grant_reg;
    else if (r1_req)
      sel = 1'b1;
  end

  assign sel_we    = sel ? r1_we    : r0_we;
  assign sel_addr  = sel ? r1_addr  : r0_addr;
  assign sel_wdata = sel ? r1_wdata : r0_wdata;
  assign sel_wstrb = sel ? r1_wstrb : r0_wstrb;

  // A channel counts as done once its valid has dropped or is handshaking now.
  assign aw_done = ~awvalid_reg | m_axi_awready;
  assign w_done  = ~wvalid_reg  | m_axi_wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      araddr_reg     <= '0;
      awaddr_reg     <= '0;
      wdata_reg      <= '0;
      wstrb_reg      <= '0;
      arvalid_reg    <= 1'b0;
      rready_reg     <= 1'b0;
      awvalid_reg    <= 1'b0;
      wvalid_reg     <= 1'b0;
      bready_reg     <= 1'b0;
      r0_ack_reg     <= 1'b0;
      r1_ack_reg     <= 1'b0;
      r0_rdata_reg   <= '0;
      r1_rdata_reg   <= '0;
      r0_err_reg     <= 1'b0;
      r1_err_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (r0_req || r1_req) begin
            grant_reg      <= sel;
            last_grant_reg <= sel;
            if (sel_we) begin
              awaddr_reg  <= sel_addr;
              wdata_reg   <= sel_wdata;
              wstrb_reg   <= sel_wstrb;
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
              state_reg   <= AW_W;
            end else begin
              araddr_reg  <= sel_addr;
              arvalid_reg <= 1'b1;
              state_reg   <= AR;
            end
          end
        end
        AR: begin
          if (m_axi_arready) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            state_reg   <= R;
          end
        end
        R: begin
          if (m_axi_rvalid) begin
            rready_reg <= 1'b0;
            if (grant_reg) begin
              r1_ack_reg   <= 1'b1;
              r1_rdata_reg <= m_axi_rdata;
              r1_err_reg   <= m_axi_rresp[1];
            end else begin
              r0_ack_reg   <= 1'b1;
              r0_rdata_reg <= m_axi_rdata;
              r0_err_reg   <= m_axi_rresp[1];
            end
            state_reg <= RESP;
          end
        end
        AW_W: begin
          if (awvalid_reg && m_axi_awready)
            awvalid_reg <= 1'b0;
          if (wvalid_reg && m_axi_wready)
            wvalid_reg <= 1'b0;
          if (aw_done && w_done) begin
            bready_reg <= 1'b1;
            state_reg  <= B;
          end
        end
        B: begin
          if (m_axi_bvalid) begin
            bready_reg <= 1'b0;
            if (grant_reg) begin
              r1_ack_reg   <= 1'b1;
              r1_rdata_reg <= '0;
              r1_err_reg   <= m_axi_bresp[1];
            end else begin
              r0_ack_reg   <= 1'b1;
              r0_rdata_reg <= '0;
              r0_err_reg   <= m_axi_bresp[1];
            end
            state_reg <= RESP;
          end
        end
        RESP: begin
          r0_ack_reg   <= 1'b0;
          r1_ack_reg   <= 1'b0;
          r0_rdata_reg <= '0;
          r1_rdata_reg <= '0;
          r0_err_reg   <= 1'b0;
          r1_err_reg   <= 1'b0;
          state_reg    <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign m_axi_araddr  = araddr_reg;
  assign m_axi_arvalid = arvalid_reg;
  assign m_axi_rready  = rready_reg;
  assign m_axi_awaddr  = awaddr_reg;
  assign m_axi_awvalid = awvalid_reg;
  assign m_axi_wdata   = wdata_reg;
  assign m_axi_wstrb   = wstrb_reg;
  assign m_axi_wvalid  = wvalid_reg;
  assign m_axi_bready  = bready_reg;

  assign r0_ack   = r0_ack_reg;
  assign r1_ack   = r1_ack_reg;
  assign r0_rdata = r0_rdata_reg;
  assign r1_rdata = r1_rdata_reg;
  assign r0_err   = r0_err_reg;
  assign r1_err   = r1_err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a behavioural AXI slave with programmable
// per-channel delays, requester tasks and hand-computed expectations.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
  logic [31:0] r0_addr = 0, r0_wdata = 0, r1_addr = 0, r1_wdata = 0;
  logic [3:0]  r0_wstrb = 0, r1_wstrb = 0;
  logic        r0_ack, r1_ack, r0_err, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic [31:0] m_axi_araddr, m_axi_awaddr, m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready;
  logic        m_axi_arready = 0, m_axi_rvalid = 0, m_axi_awready = 0, m_axi_wready = 0;
  logic        m_axi_bvalid = 0;
  logic [31:0] m_axi_rdata = 0;
  logic [1:0]  m_axi_rresp = 0, m_axi_bresp = 0;

  int checks = 0;
  int failures = 0;

  // Slave behaviour knobs
  int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [31:0] sl_rdata = 32'hDEADBEEF;
  logic [1:0]  sl_rresp = 2'b00, sl_bresp = 2'b00;
  logic        obs_aw2, obs_w2;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_wstrb(r0_wstrb), .r0_ack(r0_ack), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_wstrb(r1_wstrb), .r1_ack(r1_ack), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Slave: decides its ready/valid for the next edge from what it sees at the negedge.
  initial begin
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_awready = 0;
        m_axi_wready = 0; m_axi_bvalid = 0;
      end else begin
        if (m_axi_arvalid) begin m_axi_arready = (ar_cnt == ar_dly); ar_cnt++; end
        else begin m_axi_arready = 0; ar_cnt = 0; end
        if (m_axi_awvalid) begin m_axi_awready = (aw_cnt == aw_dly); aw_cnt++; end
        else begin m_axi_awready = 0; aw_cnt = 0; end
        if (m_axi_wvalid) begin m_axi_wready = (w_cnt == w_dly); w_cnt++; end
        else begin m_axi_wready = 0; w_cnt = 0; end
        if (m_axi_rready) begin
          m_axi_rvalid = (r_cnt == r_dly); r_cnt++;
          m_axi_rdata = sl_rdata; m_axi_rresp = sl_rresp;
        end else begin m_axi_rvalid = 0; r_cnt = 0; end
        if (m_axi_bready) begin
          m_axi_bvalid = (b_cnt == b_dly); b_cnt++; m_axi_bresp = sl_bresp;
        end else begin m_axi_bvalid = 0; b_cnt = 0; end
      end
    end
  end

  task automatic set_req(input int n, input logic v, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] st);
    if (n == 1) begin r1_req = v; r1_we = we; r1_addr = addr; r1_wdata = wd; r1_wstrb = st; end
    else        begin r0_req = v; r0_we = we; r0_addr = addr; r0_wdata = wd; r0_wstrb = st; end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {23'd0, m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid,
          m_axi_bready, r0_ack, r1_ack, r0_err, r1_err}, 32'd0);
    check({tag, "_data"}, m_axi_araddr | m_axi_awaddr | m_axi_wdata | r0_rdata | r1_rdata |
          {28'd0, m_axi_wstrb}, 32'd0);
  endtask

  // Single-requester transaction; entered and left at a negedge.
  task automatic run_txn(input string tag, input int n, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] st, input int exp_lat,
                         input logic [31:0] exp_rdata, input logic exp_err);
    int cyc, other, bcnt;
    bit got;
    logic my_ack;
    cyc = 0; other = 0; bcnt = 0; got = 0;
    set_req(n, 1'b1, we, addr, wd, st);
    while (!got && cyc < 200) begin
      @(posedge clk); @(negedge clk); cyc++;
      if (cyc == 2) begin obs_aw2 = m_axi_awvalid; obs_w2 = m_axi_wvalid; end
      if (m_axi_bready) bcnt++;
      if ((n == 1 ? r0_ack : r1_ack) === 1'b1) other++;
      my_ack = (n == 1) ? r1_ack : r0_ack;
      if (my_ack === 1'b1) begin
        got = 1;
        set_req(n, 1'b0, we, addr, wd, st);
        check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_rdata"}, (n == 1) ? r1_rdata : r0_rdata, exp_rdata);
        check({tag, "_err"}, {31'd0, (n == 1) ? r1_err : r0_err}, {31'd0, exp_err});
        if (we) begin
          check({tag, "_awaddr"}, m_axi_awaddr, addr);
          check({tag, "_wdata"}, m_axi_wdata, wd);
          check({tag, "_wstrb"}, {28'd0, m_axi_wstrb}, {28'd0, st});
        end else begin
          check({tag, "_araddr"}, m_axi_araddr, addr);
        end
      end
    end
    if (!got) check({tag, "_timeout"}, 32'd0, 32'd1);
    check({tag, "_other_ack"}, 32'(other), 32'd0);
    if (we) check({tag, "_bready_cycles"}, 32'(bcnt), 32'(b_dly + 1));
    @(posedge clk); @(negedge clk);
    check({tag, "_ack_one_cycle"}, {31'd0, (n == 1) ? r1_ack : r0_ack}, 32'd0);
    $display("txn %s req=%0d we=%0d addr=0x%08h latency=%0d", tag, n, we, addr, cyc);
  endtask

  // Both requesters raise a read in the same cycle; report who is acked first.
  task automatic run_both(input string tag, input int exp_first);
    int first, cyc;
    bit d0, d1;
    first = -1; cyc = 0; d0 = 0; d1 = 0;
    set_req(0, 1'b1, 1'b0, 32'h300, 32'd0, 4'd0);
    set_req(1, 1'b1, 1'b0, 32'h304, 32'd0, 4'd0);
    while (!(d0 && d1) && cyc < 100) begin
      @(posedge clk); @(negedge clk); cyc++;
      if (r0_ack === 1'b1 && !d0) begin
        if (first < 0) first = 0;
        d0 = 1; r0_req = 0;
      end
      if (r1_ack === 1'b1 && !d1) begin
        if (first < 0) first = 1;
        d1 = 1; r1_req = 0;
      end
    end
    check({tag, "_first"}, 32'(first), 32'(exp_first));
    check({tag, "_both_done"}, {30'd0, d1, d0}, 32'd3);
    @(posedge clk); @(negedge clk);
    $display("txn %s both-request first=%0d cycles=%0d", tag, first, cyc);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    int stall_ok, ack_seen;
    do_reset();
    check_reset_outputs("reset");

    // Zero-wait read and write: ack three cycles after the request is sampled.
    run_txn("rd_basic", 0, 1'b0, 32'h00000100, 32'd0, 4'd0, 3, 32'hDEADBEEF, 1'b0);
    run_txn("wr_basic", 0, 1'b1, 32'h00000180, 32'hA5A5_0F0F, 4'h3, 3, 32'd0, 1'b0);

    // Collision right after reset goes to r0. A lone r0 grant then leaves the
    // pointer on r0, so the next collision must go to r1.
    do_reset();
    run_both("both_after_rst", 0);
    run_txn("rd_solo_r0", 0, 1'b0, 32'h00000108, 32'd0, 4'd0, 3, 32'hDEADBEEF, 1'b0);
    run_both("both_alternate", 1);

    // awready comes two cycles before wready: AW drops alone in cycle 2.
    w_dly = 2;
    run_txn("wr_split", 1, 1'b1, 32'h00000200, 32'h12345678, 4'hF, 5, 32'd0, 1'b0);
    check("wr_split_awvalid_c2", {31'd0, obs_aw2}, 32'd0);
    check("wr_split_wvalid_c2", {31'd0, obs_w2}, 32'd1);
    w_dly = 0;

    // Error responses; read data still passes through. Read also has stalls.
    sl_rresp = 2'b10; sl_rdata = 32'hCAFEF00D; ar_dly = 2; r_dly = 1;
    run_txn("rd_err", 0, 1'b0, 32'h00000110, 32'd0, 4'd0, 6, 32'hCAFEF00D, 1'b1);
    sl_rresp = 2'b00; ar_dly = 0; r_dly = 0;
    sl_bresp = 2'b10;
    run_txn("wr_err", 1, 1'b1, 32'h00000210, 32'h0BADC0DE, 4'h1, 3, 32'd0, 1'b1);
    sl_bresp = 2'b00;

    // Stall in R, then reset: transaction abandoned, nothing acked.
    r_dly = 1000;
    set_req(0, 1'b1, 1'b0, 32'h00000400, 32'd0, 4'd0);
    for (int i = 0; i < 20 && m_axi_rready !== 1'b1; i++) begin
      @(posedge clk); @(negedge clk);
    end
    stall_ok = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      if (!(m_axi_rready === 1'b1 && m_axi_arvalid === 1'b0 && r0_ack === 1'b0 &&
            m_axi_araddr === 32'h400)) stall_ok = 0;
    end
    check("stall_r_hold", 32'(stall_ok), 32'd1);
    rst = 1;
    @(posedge clk); @(negedge clk);
    check_reset_outputs("rst_mid_txn");
    r0_req = 0; rst = 0; r_dly = 0;
    ack_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      if (r0_ack !== 1'b0 || r1_ack !== 1'b0) ack_seen++;
    end
    check("rst_mid_txn_no_ack", 32'(ack_seen), 32'd0);
    sl_rdata = 32'h5555AAAA;
    run_txn("rd_after_rst", 1, 1'b0, 32'h00000500, 32'd0, 4'd0, 3, 32'h5555AAAA, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
